// File: rtl/sprite_blitter.sv
// XOR sprite blitter with an internal DISP_H x DISP_W framebuffer.
// One sprite row (or one clear row) is read-modify-written per clock.
module sprite_blitter #(
   parameter int unsigned DISP_W   = 64,
   parameter int unsigned DISP_H   = 32,
   parameter int unsigned MAX_ROWS = 15,
   parameter int unsigned WRAP     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        gpu_clear,
   input  logic                        gpu_draw,
   input  logic [7:0]                  vx,
   input  logic [7:0]                  vy,
   input  logic [3:0]                  n_bits,
   input  logic [8*MAX_ROWS-1:0]       sprite_data,
   output logic                        busy,
   output logic                        done,
   output logic [7:0]                  vf,
   input  logic [$clog2(DISP_H)-1:0]   rd_row,
   output logic [DISP_W-1:0]           rd_data
);

   localparam int unsigned XW    = $clog2(DISP_W);
   localparam int unsigned YW    = $clog2(DISP_H);
   localparam int unsigned SW    = YW + 5;
   localparam int unsigned SPR_W = 8 * MAX_ROWS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DRAW,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [XW-1:0]     x0_q;
   logic [YW-1:0]     y0_q;
   logic [3:0]        n_q;
   logic [3:0]        k_q;
   logic [SPR_W-1:0]  spr_q;
   logic              coll_q;
   logic [YW-1:0]     clr_row_q;
   logic [DISP_W-1:0] fb [DISP_H];

   logic [3:0]        n_in;
   logic [XW-1:0]     x0_in;
   logic [YW-1:0]     y0_in;
   logic              accept_draw;
   logic              last_clear;
   logic              last_row;

   logic [7:0]          row_byte;
   logic [SW-1:0]       y_full;
   logic                y_skip;
   logic [YW-1:0]       y_row;
   logic [2*DISP_W-1:0] wide;
   logic [DISP_W-1:0]   mask;
   logic [DISP_W-1:0]   old_row;

   logic                wr_en;
   logic [YW-1:0]       wr_row;
   logic [DISP_W-1:0]   wr_data;
   logic                hit;

   // Request decode: coordinates reduced to the display, height clamped.
   always_comb begin
      n_in        = (n_bits > 4'(MAX_ROWS)) ? 4'(MAX_ROWS) : n_bits;
      x0_in       = XW'(vx % 8'(DISP_W));
      y0_in       = YW'(vy % 8'(DISP_H));
      accept_draw = (state == S_IDLE) && gpu_draw && !gpu_clear;
      last_clear  = (clr_row_q == YW'(DISP_H - 1));
      last_row    = (k_q == n_q - 4'd1);
   end

   // Row geometry: the byte is placed at x0 inside a double-width window so
   // the columns that fall off the right edge land in the low half.
   always_comb begin
      row_byte = spr_q[SPR_W-1 -: 8];
      y_full   = SW'(y0_q) + SW'(k_q);
      y_skip   = (WRAP == 0) && (y_full >= SW'(DISP_H));
      y_row    = y_full[YW-1:0];
      wide     = {row_byte, {(2*DISP_W-8){1'b0}}} >> x0_q;
      mask     = (WRAP != 0) ? (wide[2*DISP_W-1:DISP_W] | wide[DISP_W-1:0])
                             : wide[2*DISP_W-1:DISP_W];
      old_row  = fb[y_row];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (gpu_clear) begin
               state_nx = S_CLEAR;
            end else if (gpu_draw) begin
               state_nx = (n_in == 4'd0) ? S_DONE : S_DRAW;
            end
         end
         S_CLEAR: if (last_clear) state_nx = S_DONE;
         S_DRAW:  if (last_row)   state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Framebuffer write port and collision detect for the current row.
   always_comb begin
      wr_en   = 1'b0;
      wr_row  = '0;
      wr_data = '0;
      hit     = 1'b0;
      case (state)
         S_CLEAR: begin
            wr_en  = 1'b1;
            wr_row = clr_row_q;
         end
         S_DRAW: begin
            if (!y_skip) begin
               wr_en   = 1'b1;
               wr_row  = y_row;
               wr_data = old_row ^ mask;
               hit     = |(old_row & mask);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         vf        <= 8'h00;
         x0_q      <= '0;
         y0_q      <= '0;
         n_q       <= '0;
         k_q       <= '0;
         spr_q     <= '0;
         coll_q    <= 1'b0;
         clr_row_q <= '0;
      end else begin
         busy <= (state_nx != S_IDLE);
         done <= (state_nx == S_DONE);
         case (state)
            S_IDLE: begin
               clr_row_q <= '0;
               k_q       <= '0;
               if (accept_draw) begin
                  x0_q   <= x0_in;
                  y0_q   <= y0_in;
                  n_q    <= n_in;
                  spr_q  <= sprite_data;
                  coll_q <= 1'b0;
                  if (n_in == 4'd0) vf <= 8'h00;
               end
            end
            S_CLEAR: clr_row_q <= clr_row_q + YW'(1);
            S_DRAW: begin
               k_q    <= k_q + 4'd1;
               spr_q  <= spr_q << 8;
               coll_q <= coll_q | hit;
               if (last_row) vf <= {7'b0, coll_q | hit};
            end
            default: ;
         endcase
      end
   end

   // Reset clears every row; otherwise one row is written per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DISP_H); i++) fb[i] <= '0;
      end else if (wr_en) begin
         fb[wr_row] <= wr_data;
      end
   end

   assign rd_data = fb[rd_row];

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a clip/15-row instance and a wrap/4-row instance
// driven in lockstep and compared against a pixel-level reference model.
`timescale 1ns/100ps
module tb_sprite_blitter;

   logic         clk = 1'b0;
   logic         rst;
   logic         gpu_clear;
   logic         gpu_draw;
   logic [7:0]   vx;
   logic [7:0]   vy;
   logic [3:0]   n_bits;
   logic [119:0] spr;
   logic [4:0]   rd_row;
   logic         busy0, done0, busy1, done1;
   logic [7:0]   vf0, vf1;
   logic [63:0]  rd0, rd1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m_fb [2][32];
   logic [7:0]  m_vf [2];

   always #5 clk = ~clk;

   sprite_blitter #(.DISP_W(64), .DISP_H(32), .MAX_ROWS(15), .WRAP(0)) dut0 (
      .clk(clk), .rst(rst), .gpu_clear(gpu_clear), .gpu_draw(gpu_draw),
      .vx(vx), .vy(vy), .n_bits(n_bits), .sprite_data(spr),
      .busy(busy0), .done(done0), .vf(vf0), .rd_row(rd_row), .rd_data(rd0)
   );

   sprite_blitter #(.DISP_W(64), .DISP_H(32), .MAX_ROWS(4), .WRAP(1)) dut1 (
      .clk(clk), .rst(rst), .gpu_clear(gpu_clear), .gpu_draw(gpu_draw),
      .vx(vx), .vy(vy), .n_bits(n_bits), .sprite_data(spr[119:88]),
      .busy(busy1), .done(done1), .vf(vf1), .rd_row(rd_row), .rd_data(rd1)
   );

   function automatic int max_rows(input int d);
      return (d == 1) ? 4 : 15;
   endfunction

   function automatic bit wraps(input int d);
      return d == 1;
   endfunction

   function automatic logic [119:0] rand_spr();
      return 120'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      vx     = 8'($urandom);
      vy     = 8'($urandom);
      n_bits = 4'($urandom);
      spr    = rand_spr();
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 32; r++) m_fb[d][r] = '0;
         m_vf[d] = 8'h00;
      end
   endtask

   // Pixel-by-pixel XOR plot: pixel x lives at bit 63-x of row y.
   task automatic model_draw(input int d, input int x_in, input int y_in,
                             input int nb, input logic [119:0] s);
      int n, x, y;
      logic [7:0] b;
      bit coll;
      n    = (nb > max_rows(d)) ? max_rows(d) : nb;
      coll = 0;
      for (int k = 0; k < n; k++) begin
         b = s[119-8*k -: 8];
         for (int i = 0; i < 8; i++) begin
            if (b[7-i]) begin
               x = (x_in % 64) + i;
               y = (y_in % 32) + k;
               if (x >= 64) begin
                  if (!wraps(d)) continue;
                  x = x - 64;
               end
               if (y >= 32) begin
                  if (!wraps(d)) continue;
                  y = y - 32;
               end
               if (m_fb[d][y][63-x]) coll = 1;
               m_fb[d][y][63-x] = ~m_fb[d][y][63-x];
            end
         end
      end
      m_vf[d] = {7'b0, coll};
   endtask

   function automatic int exp_busy(input int d, input bit clr, input int nb);
      int n;
      if (clr) return 33;
      n = (nb > max_rows(d)) ? max_rows(d) : nb;
      return (n == 0) ? 1 : n + 1;
   endfunction

   task automatic check_fb(input string tag);
      for (int r = 0; r < 32; r++) begin
         rd_row = 5'(r);
         #1;
         check_eq($sformatf("%s dut0 row%0d", tag, r), rd0, m_fb[0][r]);
         check_eq($sformatf("%s dut1 row%0d", tag, r), rd1, m_fb[1][r]);
      end
      check_eq({tag, " dut0 vf"}, 64'(vf0), 64'(m_vf[0]));
      check_eq({tag, " dut1 vf"}, 64'(vf1), 64'(m_vf[1]));
   endtask

   // Issue one request, watch busy/done of both instances, then update the model.
   task automatic run_op(input string tag, input bit clr, input bit drw,
                         input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] nb, input logic [119:0] s, input bit poke);
      int bc [2];
      int dc [2];
      int dcyc [2];
      int cyc;
      for (int d = 0; d < 2; d++) begin
         bc[d] = 0; dc[d] = 0; dcyc[d] = 0;
      end
      gpu_clear = clr; gpu_draw = drw; vx = x; vy = y; n_bits = nb; spr = s;
      tick();
      gpu_clear = 1'b0; gpu_draw = 1'b0;
      randomize_inputs();
      cyc = 0;
      while ((busy0 || busy1) && cyc < 200) begin
         cyc++;
         if (busy0) bc[0]++;
         if (busy1) bc[1]++;
         if (done0) begin dc[0]++; dcyc[0] = cyc; end
         if (done1) begin dc[1]++; dcyc[1] = cyc; end
         if (poke) gpu_draw = (cyc == 2);
         tick();
      end
      gpu_draw = 1'b0;
      check_eq({tag, " terminates"}, 64'(cyc < 200), 64'd1);
      repeat (3) begin
         if (busy0) bc[0]++;
         if (busy1) bc[1]++;
         if (done0) dc[0]++;
         if (done1) dc[1]++;
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         if (clr) begin
            for (int r = 0; r < 32; r++) m_fb[d][r] = '0;
         end else begin
            model_draw(d, int'(x), int'(y), int'(nb), s);
         end
         check_eq($sformatf("%s dut%0d busy cycles", tag, d), 64'(bc[d]), 64'(exp_busy(d, clr, int'(nb))));
         check_eq($sformatf("%s dut%0d done pulses", tag, d), 64'(dc[d]), 64'd1);
         check_eq($sformatf("%s dut%0d done cycle", tag, d), 64'(dcyc[d]), 64'(exp_busy(d, clr, int'(nb))));
      end
      check_fb(tag);
   endtask

   initial begin
      logic [119:0] s;
      int got_done;

      rst = 1'b1; rd_row = '0;
      gpu_clear = 1'b1; gpu_draw = 1'b1;
      randomize_inputs();
      model_reset();
      repeat (3) begin
         tick();
         gpu_clear = 1'($urandom); gpu_draw = 1'($urandom);
         randomize_inputs();
      end
      check_eq("reset busy0", 64'(busy0), 64'd0);
      check_eq("reset done0", 64'(done0), 64'd0);
      check_eq("reset busy1", 64'(busy1), 64'd0);
      check_eq("reset done1", 64'(done1), 64'd0);
      check_fb("reset");
      gpu_clear = 1'b0; gpu_draw = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      s = '0; s[119:112] = 8'hF0;
      run_op("draw_f0", 0, 1, 8'd0, 8'd0, 4'd1, s, 0);
      rd_row = 5'd0; #1;
      check_eq("draw_f0 row0 value", rd0, 64'hF000_0000_0000_0000);
      check_eq("draw_f0 vf value", 64'(vf0), 64'd0);
      run_op("erase_f0", 0, 1, 8'd0, 8'd0, 4'd1, s, 0);
      rd_row = 5'd0; #1;
      check_eq("erase_f0 row0 value", rd0, 64'd0);
      check_eq("erase_f0 vf value", 64'(vf0), 64'd1);

      run_op("clear_a", 1, 0, 8'd0, 8'd0, 4'd0, '0, 0);
      s = {24'hFF_FFFF, 96'd0};
      run_op("clipwrap", 0, 1, 8'd60, 8'd30, 4'd3, s, 0);
      for (int r = 30; r < 32; r++) begin
         rd_row = 5'(r); #1;
         check_eq($sformatf("clip row%0d", r), rd0, 64'h0000_0000_0000_000F);
         check_eq($sformatf("wrap row%0d", r), rd1, 64'hF000_0000_0000_000F);
      end
      rd_row = 5'd0; #1;
      check_eq("clip row0", rd0, 64'd0);
      check_eq("wrap row0", rd1, 64'hF000_0000_0000_000F);

      run_op("clear_b", 1, 0, 8'd0, 8'd0, 4'd0, '0, 0);
      run_op("modulo", 0, 1, 8'd70, 8'd33, 4'd1, {8'h80, 112'd0}, 0);
      rd_row = 5'd1; #1;
      check_eq("modulo row1", rd0, 64'h0200_0000_0000_0000);
      run_op("clamp", 0, 1, 8'($urandom), 8'($urandom), 4'd15, rand_spr(), 0);
      run_op("zero_rows", 0, 1, 8'($urandom), 8'($urandom), 4'd0, rand_spr(), 0);

      run_op("clear_and_draw", 1, 1, 8'd5, 8'd5, 4'd3, rand_spr(), 0);
      run_op("draw_poke", 0, 1, 8'($urandom), 8'($urandom), 4'd5, rand_spr(), 1);

      for (int t = 0; t < 40; t++) begin
         run_op($sformatf("rand%0d", t), ($urandom % 10) == 0, 1,
                8'($urandom), 8'($urandom), 4'($urandom), rand_spr(), 1'($urandom));
      end

      // Abort a 5-row draw while it is working on sprite row 2.
      gpu_draw = 1'b1; vx = 8'($urandom); vy = 8'($urandom); n_bits = 4'd5; spr = rand_spr();
      tick();
      gpu_draw = 1'b0;
      tick();
      tick();
      check_eq("abort busy before reset", 64'(busy0), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("abort busy0 async", 64'(busy0), 64'd0);
      check_eq("abort busy1 async", 64'(busy1), 64'd0);
      model_reset();
      got_done = 0;
      tick();
      rst = 1'b0;
      repeat (4) begin
         if (done0 || done1 || busy0 || busy1) got_done++;
         tick();
      end
      check_eq("abort no done", 64'(got_done), 64'd0);
      check_fb("abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
